// File: rtl/evr_rx_decoder_pkg.sv
// Shared event-system package used by the EVG and EVR sides.
// Holds the timing-system event codes, the 8b10b comma character and
// the receiver link-state encoding.
package evr_rx_decoder_pkg;

    localparam logic [7:0] EVT_SEC_0     = 8'h70;  // shift a 0 into seconds
    localparam logic [7:0] EVT_SEC_1     = 8'h71;  // shift a 1 into seconds
    localparam logic [7:0] EVT_HEARTBEAT = 8'h7A;  // heartbeat
    localparam logic [7:0] EVT_PPS       = 8'h7D;  // latch seconds, PPS edge
    localparam logic [7:0] K28_5_COMMA   = 8'hBC;  // K28.5 comma character

    typedef enum logic [1:0] {
        LINK_LOS  = 2'd0,
        LINK_SYNC = 2'd1,
        LINK_UP   = 2'd2
    } link_state_e;

endpackage

// File: rtl/evr_rx_decoder_link_fsm.sv
// Link FSM for the EVR receiver: qualifies each 16-bit word, tracks
// LOS/SYNC/UP, watches comma spacing in UP and counts word errors.
// Ports:
//   clk, rst_n          clock, async active-low reset (already synchronised)
//   rx_code             low byte of the received word
//   rx_char_is_k        per-byte K flags
//   rx_code_err         per-byte code/disparity errors
//   link_up             state is UP
//   decode_en           good word received in UP that keeps the link UP
//   to_los              this word moves the link into LOS
//   error_count         saturating count of bad words seen in SYNC/UP
module evr_link_fsm
    import evr_rx_decoder_pkg::*;
#(
    parameter int unsigned COMMA_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_code,
    input  logic [1:0]  rx_char_is_k,
    input  logic [1:0]  rx_code_err,
    output logic        link_up,
    output logic        decode_en,
    output logic        to_los,
    output logic [15:0] error_count
);

    localparam int unsigned CT_W = $clog2(COMMA_TIMEOUT + 1);

    link_state_e     state_q, state_d;
    logic [3:0]      sync_cnt_q, sync_cnt_d;
    logic [CT_W-1:0] nocomma_cnt_q, nocomma_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            good_word;
    logic            comma;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LINK_LOS;
            sync_cnt_q    <= '0;
            nocomma_cnt_q <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            nocomma_cnt_q <= nocomma_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        good_word = (rx_code_err == 2'b00) && !rx_char_is_k[1] &&
                    (!rx_char_is_k[0] || (rx_code == K28_5_COMMA));
        comma     = good_word && rx_char_is_k[0];

        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        err_cnt_d  = err_cnt_q;

        // Words since the last comma; saturates so it cannot wrap in LOS.
        if (comma)
            nocomma_cnt_d = '0;
        else if (nocomma_cnt_q != CT_W'(COMMA_TIMEOUT))
            nocomma_cnt_d = nocomma_cnt_q + 1'b1;
        else
            nocomma_cnt_d = nocomma_cnt_q;

        unique case (state_q)
            LINK_LOS: begin
                if (comma) begin
                    state_d    = LINK_SYNC;
                    sync_cnt_d = 4'd1;  // the comma itself is the first good word
                end
            end
            LINK_SYNC: begin
                if (!good_word)
                    state_d = LINK_LOS;
                else if (sync_cnt_q == 4'd15)
                    state_d = LINK_UP;
                else
                    sync_cnt_d = sync_cnt_q + 1'b1;
            end
            LINK_UP: begin
                if (!good_word || (nocomma_cnt_d == CT_W'(COMMA_TIMEOUT)))
                    state_d = LINK_LOS;
            end
            default: state_d = LINK_LOS;
        endcase

        if ((state_q != LINK_LOS) && !good_word && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    // Outputs
    always_comb begin
        link_up     = (state_q == LINK_UP);
        to_los      = (state_q != LINK_LOS) && (state_d == LINK_LOS);
        decode_en   = (state_q == LINK_UP) && (state_d == LINK_UP);
        error_count = err_cnt_q;
    end

endmodule

// File: rtl/evr_rx_decoder.sv
// EVR receive decoder: turns the recovered 16-bit 8b10b word stream into
// event strobes, distributed bus, time-of-day seconds, PPS toggle and a
// heartbeat watchdog. Link tracking lives in evr_link_fsm.
// Ports:
//   evrRxClk, evrRxRst_n     recovered clock, async active-low reset
//   evrRxData/CharIsK/CodeErr  received word, K flags, code errors
//   evrLinkUp                link state UP
//   evrEventTDATA/TVALID     decoded event code and one-cycle strobe
//   evrDistributedBus        latched upper-byte distributed bus
//   evrSeconds/SecondsValid  last latched seconds and its completeness
//   evrPPStoggle             toggles on each PPS event
//   evrHeartbeatStrobe/Missing  heartbeat pulse and watchdog flag
//   evrErrorCount            saturating word-error count
module evr_rx_decoder
    import evr_rx_decoder_pkg::*;
#(
    parameter int unsigned TOD_SECONDS_WIDTH     = 32,
    parameter int unsigned DISTRIBUTED_BUS_WIDTH = 8,
    parameter int unsigned COMMA_TIMEOUT         = 1024,
    parameter int unsigned HEARTBEAT_TIMEOUT     = 250000000
) (
    input  logic                             evrRxClk,
    input  logic                             evrRxRst_n,
    input  logic [15:0]                      evrRxData,
    input  logic [1:0]                       evrRxCharIsK,
    input  logic [1:0]                       evrRxCodeErr,
    output logic                             evrLinkUp,
    output logic [7:0]                       evrEventTDATA,
    output logic                             evrEventTVALID,
    output logic [DISTRIBUTED_BUS_WIDTH-1:0] evrDistributedBus,
    output logic [TOD_SECONDS_WIDTH-1:0]     evrSeconds,
    output logic                             evrSecondsValid,
    output logic                             evrPPStoggle,
    output logic                             evrHeartbeatStrobe,
    output logic                             evrHeartbeatMissing,
    output logic [15:0]                      evrErrorCount
);

    localparam int unsigned SC_W = $clog2(TOD_SECONDS_WIDTH + 2);
    localparam int unsigned HB_W = $clog2(HEARTBEAT_TIMEOUT + 1);

    logic [1:0]                       rst_sync_q, rst_sync_d;
    logic                             rst_n_int;
    logic                             decode_en, to_los, ev_fire;
    logic [7:0]                       code;
    logic [7:0]                       tdata_q, tdata_d;
    logic                             tvalid_q, tvalid_d;
    logic [DISTRIBUTED_BUS_WIDTH-1:0] dbus_q, dbus_d;
    logic [TOD_SECONDS_WIDTH-1:0]     shift_q, shift_d, seconds_q, seconds_d;
    logic [SC_W-1:0]                  bit_cnt_q, bit_cnt_d;
    logic                             sec_valid_q, sec_valid_d;
    logic                             pps_q, pps_d;
    logic                             hb_strobe_q, hb_strobe_d;
    logic [HB_W-1:0]                  hb_cnt_q, hb_cnt_d;
    logic                             hb_missing_q, hb_missing_d;

    // Asserts asynchronously, releases two clocks after evrRxRst_n rises.
    always_ff @(posedge evrRxClk or negedge evrRxRst_n) begin
        if (!evrRxRst_n) rst_sync_q <= '0;
        else             rst_sync_q <= rst_sync_d;
    end
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_int  = rst_sync_q[1];

    evr_link_fsm #(
        .COMMA_TIMEOUT (COMMA_TIMEOUT)
    ) u_link_fsm (
        .clk          (evrRxClk),
        .rst_n        (rst_n_int),
        .rx_code      (evrRxData[7:0]),
        .rx_char_is_k (evrRxCharIsK),
        .rx_code_err  (evrRxCodeErr),
        .link_up      (evrLinkUp),
        .decode_en    (decode_en),
        .to_los       (to_los),
        .error_count  (evrErrorCount)
    );

    always_ff @(posedge evrRxClk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            dbus_q       <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            seconds_q    <= '0;
            sec_valid_q  <= 1'b0;
            pps_q        <= 1'b0;
            hb_strobe_q  <= 1'b0;
            hb_cnt_q     <= '0;
            hb_missing_q <= 1'b1;
        end else begin
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            dbus_q       <= dbus_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            seconds_q    <= seconds_d;
            sec_valid_q  <= sec_valid_d;
            pps_q        <= pps_d;
            hb_strobe_q  <= hb_strobe_d;
            hb_cnt_q     <= hb_cnt_d;
            hb_missing_q <= hb_missing_d;
        end
    end

    always_comb begin
        code = evrRxData[7:0];
        // decode_en already implies a good word; K[0] here can only be a comma.
        ev_fire = decode_en && !evrRxCharIsK[0] && (code != 8'h00);

        tdata_d      = ev_fire ? code : tdata_q;
        tvalid_d     = ev_fire;
        dbus_d       = decode_en ? evrRxData[DISTRIBUTED_BUS_WIDTH+7:8] : dbus_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        seconds_d    = seconds_q;
        sec_valid_d  = sec_valid_q;
        pps_d        = pps_q;
        hb_strobe_d  = ev_fire && (code == EVT_HEARTBEAT);
        hb_cnt_d     = hb_cnt_q;
        hb_missing_d = hb_missing_q;

        if (to_los) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (ev_fire) begin
            unique case (code)
                EVT_SEC_0, EVT_SEC_1: begin
                    shift_d = {shift_q[TOD_SECONDS_WIDTH-2:0], code[0]};
                    if (bit_cnt_q != SC_W'(TOD_SECONDS_WIDTH + 1))
                        bit_cnt_d = bit_cnt_q + 1'b1;
                end
                EVT_PPS: begin
                    seconds_d   = shift_q;
                    sec_valid_d = (bit_cnt_q == SC_W'(TOD_SECONDS_WIDTH));
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    pps_d       = ~pps_q;
                end
                default: ;
            endcase
        end

        // Watchdog: cycles since the last heartbeat, parked at the timeout.
        if (hb_strobe_d) begin
            hb_cnt_d     = '0;
            hb_missing_d = 1'b0;
        end else if (hb_cnt_q != HB_W'(HEARTBEAT_TIMEOUT)) begin
            hb_cnt_d = hb_cnt_q + 1'b1;
            if (hb_cnt_d == HB_W'(HEARTBEAT_TIMEOUT))
                hb_missing_d = 1'b1;
        end
    end

    assign evrEventTDATA       = tdata_q;
    assign evrEventTVALID      = tvalid_q;
    assign evrDistributedBus   = dbus_q;
    assign evrSeconds          = seconds_q;
    assign evrSecondsValid     = sec_valid_q;
    assign evrPPStoggle        = pps_q;
    assign evrHeartbeatStrobe  = hb_strobe_q;
    assign evrHeartbeatMissing = hb_missing_q;

endmodule

// File: tb/tb_evr_rx_decoder.sv
module tb_evr_rx_decoder;
    import evr_rx_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rx_data = '0;
    logic [1:0]  rx_k = '0;
    logic [1:0]  rx_err = '0;
    logic        link_up, tvalid, sec_valid, pps, hb_strobe, hb_missing;
    logic [7:0]  tdata, dbus;
    logic [31:0] seconds;
    logic [15:0] err_count;

    int errors = 0;
    int checks = 0;
    int tv_count = 0;

    evr_rx_decoder #(
        .HEARTBEAT_TIMEOUT (100)
    ) dut (
        .evrRxClk            (clk),
        .evrRxRst_n          (rst_n),
        .evrRxData           (rx_data),
        .evrRxCharIsK        (rx_k),
        .evrRxCodeErr        (rx_err),
        .evrLinkUp           (link_up),
        .evrEventTDATA       (tdata),
        .evrEventTVALID      (tvalid),
        .evrDistributedBus   (dbus),
        .evrSeconds          (seconds),
        .evrSecondsValid     (sec_valid),
        .evrPPStoggle        (pps),
        .evrHeartbeatStrobe  (hb_strobe),
        .evrHeartbeatMissing (hb_missing),
        .evrErrorCount       (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Drive one word on the falling edge; return 1 time unit after the
    // rising edge that captures it, so outputs reflect that word.
    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic [1:0] e);
        @(negedge clk);
        rx_data = d; rx_k = k; rx_err = e;
        @(posedge clk); #1;
        if (tvalid) tv_count++;
    endtask

    task automatic send_comma();
        send({8'h00, K28_5_COMMA}, 2'b01, 2'b00);
    endtask

    task automatic send_code(input logic [7:0] c);
        send({8'h00, c}, 2'b00, 2'b00);
    endtask

    task automatic lock();
        for (int i = 0; i < 16; i++) send_comma();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; rx_data = '0; rx_k = '0; rx_err = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) send(16'h0000, 2'b00, 2'b00);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL rst_link_up: got %b exp 0", link_up); end
        checks++; if (tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h exp 00", tdata); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b exp 0", tvalid); end
        checks++; if (dbus !== 8'h00) begin errors++; $display("FAIL rst_dbus: got %h exp 00", dbus); end
        checks++; if (seconds !== 32'h0) begin errors++; $display("FAIL rst_seconds: got %h exp 0", seconds); end
        checks++; if (sec_valid !== 1'b0) begin errors++; $display("FAIL rst_sec_valid: got %b exp 0", sec_valid); end
        checks++; if (pps !== 1'b0) begin errors++; $display("FAIL rst_pps: got %b exp 0", pps); end
        checks++; if (hb_strobe !== 1'b0) begin errors++; $display("FAIL rst_hb_strobe: got %b exp 0", hb_strobe); end
        checks++; if (hb_missing !== 1'b1) begin errors++; $display("FAIL rst_hb_missing: got %b exp 1", hb_missing); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL rst_err_count: got %h exp 0", err_count); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) send(16'h0000, 2'b00, 2'b00);
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL post_rst_link_up: got %b exp 0", link_up); end
    endtask

    task automatic test_lockup();
        tv_count = 0;
        for (int i = 0; i < 15; i++) send_comma();
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL lock_15_commas: got %b exp 0", link_up); end
        send(16'hA500, 2'b00, 2'b00);  // 16th good word, not a comma
        checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL lock_16th_good: got %b exp 1", link_up); end
        checks++; if (dbus !== 8'h00) begin errors++; $display("FAIL lock_dbus_not_up: got %h exp 00", dbus); end
        send(16'hA500, 2'b00, 2'b00);
        checks++; if (dbus !== 8'hA5) begin errors++; $display("FAIL lock_dbus_up: got %h exp a5", dbus); end
        checks++; if (tv_count !== 0) begin errors++; $display("FAIL lock_no_events: got %0d exp 0", tv_count); end
        apply_reset();
        lock();
        checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL lock_commas_only: got %b exp 1", link_up); end
    endtask

    task automatic test_seconds();
        logic [31:0] val;
        logic        pps0;
        val  = 32'h12345678;
        pps0 = pps;
        tv_count = 0;
        send_code(EVT_HEARTBEAT);
        for (int i = 31; i >= 0; i--) send_code(val[i] ? EVT_SEC_1 : EVT_SEC_0);
        checks++; if (seconds !== 32'h0) begin errors++; $display("FAIL sec_before_pps: got %h exp 0", seconds); end
        checks++; if (tdata !== 8'h70 || tvalid !== 1'b1) begin errors++; $display("FAIL sec_last_shift_event: got %h/%b exp 70/1", tdata, tvalid); end
        send_code(EVT_PPS);
        checks++; if (seconds !== 32'h12345678) begin errors++; $display("FAIL sec_value: got %h exp 12345678", seconds); end
        checks++; if (sec_valid !== 1'b1) begin errors++; $display("FAIL sec_valid: got %b exp 1", sec_valid); end
        checks++; if (pps !== ~pps0) begin errors++; $display("FAIL sec_pps_toggle: got %b exp %b", pps, ~pps0); end
        checks++; if (tdata !== 8'h7D) begin errors++; $display("FAIL sec_pps_tdata: got %h exp 7d", tdata); end
        send_comma();
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL sec_tvalid_one_cycle: got %b exp 0", tvalid); end
        checks++; if (tv_count !== 34) begin errors++; $display("FAIL sec_tvalid_count: got %0d exp 34", tv_count); end
        checks++; if (pps !== ~pps0) begin errors++; $display("FAIL sec_pps_once: got %b exp %b", pps, ~pps0); end
    endtask

    task automatic test_short_frames();
        logic pps0;
        for (int i = 0; i < 31; i++) send_code(EVT_SEC_1);
        send_code(EVT_PPS);
        checks++; if (seconds !== 32'h7FFFFFFF) begin errors++; $display("FAIL short31_value: got %h exp 7fffffff", seconds); end
        checks++; if (sec_valid !== 1'b0) begin errors++; $display("FAIL short31_valid: got %b exp 0", sec_valid); end
        pps0 = pps;
        send_code(EVT_PPS);
        checks++; if (seconds !== 32'h0 || sec_valid !== 1'b0) begin errors++; $display("FAIL zero_bits_latch: got %h/%b exp 0/0", seconds, sec_valid); end
        checks++; if (pps !== ~pps0) begin errors++; $display("FAIL zero_bits_pps: got %b exp %b", pps, ~pps0); end
        for (int i = 0; i < 33; i++) send_code(EVT_SEC_1);
        send_code(EVT_PPS);
        checks++; if (seconds !== 32'hFFFFFFFF) begin errors++; $display("FAIL long33_value: got %h exp ffffffff", seconds); end
        checks++; if (sec_valid !== 1'b0) begin errors++; $display("FAIL long33_valid: got %b exp 0", sec_valid); end
        for (int i = 0; i < 32; i++) send_code(EVT_SEC_1);
        send_code(EVT_PPS);
        checks++; if (sec_valid !== 1'b1) begin errors++; $display("FAIL exact32_valid: got %b exp 1", sec_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] val;
        val = 32'hA5C3_0F96;
        for (int i = 31; i >= 0; i--) send_code(val[i] ? EVT_SEC_1 : EVT_SEC_0);
        send_code(EVT_PPS);
        checks++; if (seconds !== 32'hA5C30F96) begin errors++; $display("FAIL mid_pre_value: got %h exp a5c30f96", seconds); end
        for (int i = 0; i < 10; i++) send_code(EVT_SEC_1);
        @(negedge clk);
        rst_n = 1'b0; rx_data = '0; rx_k = '0; rx_err = '0;
        #1;
        checks++; if (seconds !== 32'h0 || link_up !== 1'b0 || pps !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got %h/%b/%b exp 0/0/0", seconds, link_up, pps); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tv_count = 0;
        repeat (4) send(16'h0000, 2'b00, 2'b00);
        lock();
        checks++; if (tv_count !== 0) begin errors++; $display("FAIL mid_no_partial: got %0d exp 0", tv_count); end
        send_code(EVT_PPS);
        checks++; if (seconds !== 32'h0 || sec_valid !== 1'b0) begin errors++; $display("FAIL mid_relatch: got %h/%b exp 0/0", seconds, sec_valid); end
        checks++; if (pps !== 1'b1 || tvalid !== 1'b1) begin errors++; $display("FAIL mid_pps_after: got %b/%b exp 1/1", pps, tvalid); end
    endtask

    task automatic test_heartbeat();
        logic stayed_low;
        apply_reset();
        lock();
        send_code(EVT_HEARTBEAT);
        checks++; if (hb_strobe !== 1'b1 || hb_missing !== 1'b0) begin errors++; $display("FAIL hb_first: got %b/%b exp 1/0", hb_strobe, hb_missing); end
        stayed_low = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 89; i++) begin
                send_comma();
                if (hb_missing !== 1'b0 || hb_strobe !== 1'b0) stayed_low = 1'b0;
            end
            send_code(EVT_HEARTBEAT);
            if (hb_missing !== 1'b0 || hb_strobe !== 1'b1) stayed_low = 1'b0;
        end
        checks++; if (stayed_low !== 1'b1) begin errors++; $display("FAIL hb_period90: got %b exp 1", stayed_low); end
        for (int i = 0; i < 99; i++) send_comma();
        checks++; if (hb_missing !== 1'b0) begin errors++; $display("FAIL hb_gap99: got %b exp 0", hb_missing); end
        send_comma();
        checks++; if (hb_missing !== 1'b1) begin errors++; $display("FAIL hb_gap100_set: got %b exp 1", hb_missing); end
        send_code(EVT_HEARTBEAT);
        checks++; if (hb_missing !== 1'b0 || hb_strobe !== 1'b1) begin errors++; $display("FAIL hb_clear: got %b/%b exp 0/1", hb_missing, hb_strobe); end
    endtask

    task automatic test_errors();
        apply_reset();
        lock();
        send(16'hA500, 2'b00, 2'b00);
        tv_count = 0;
        send(16'h3C77, 2'b00, 2'b01);
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL err_link_drop: got %b exp 0", link_up); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL err_count_one: got %0d exp 1", err_count); end
        checks++; if (tv_count !== 0) begin errors++; $display("FAIL err_no_tvalid: got %0d exp 0", tv_count); end
        checks++; if (dbus !== 8'hA5) begin errors++; $display("FAIL err_dbus_hold: got %h exp a5", dbus); end
        // Comma timeout: 1024 consecutive non-comma good words drop UP
        lock();
        for (int i = 0; i < 1023; i++) send_code(8'h00);
        checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL ct_1023: got %b exp 1", link_up); end
        send_code(8'h00);
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL ct_1024: got %b exp 0", link_up); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL ct_no_error: got %0d exp 1", err_count); end
        // Saturation: each comma re-enters SYNC so the next bad word counts
        for (int i = 0; i < 65533; i++) begin
            send_comma();
            send(16'h0000, 2'b00, 2'b10);
        end
        checks++; if (err_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h exp fffe", err_count); end
        send_comma();
        send(16'h0000, 2'b10, 2'b00);
        checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h exp ffff", err_count); end
        for (int i = 0; i < 3; i++) begin
            send_comma();
            send(16'h0000, 2'b00, 2'b01);
        end
        checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h exp ffff", err_count); end
    endtask

    initial begin
        test_reset();
        test_lockup();
        test_seconds();
        test_short_frames();
        test_reset_mid_frame();
        test_heartbeat();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
